// File: rtl/load_size_ctrl.sv
// rtl/load_size_ctrl.sv - sized memory load controller with byte/halfword/word extraction
//
// Purpose: accepts a load request, holds mem_read for MEM_LATENCY cycles, then
// extracts the addressed byte/halfword/word from memory_data_out and extends it
// to 32 bits. Misaligned or illegal-size requests complete immediately with
// load_error and no memory access.
//
// Configuration macro: LOAD_SIGN_EXT_EN
//   defined   - load_signed selects sign (1) or zero (0) extension
//   undefined - all loads zero-extend, load_signed is ignored
//
// Ports:
//   clk               in   system clock, rising edge
//   reset             in   asynchronous active-high reset
//   load_req          in   load request, sampled only when idle
//   load_size_control in   [1:0] 00 byte, 01 halfword, 10 word, 11 illegal
//   addr_low          in   [1:0] byte offset of the load address
//   load_signed       in   1 = sign-extend, 0 = zero-extend
//   memory_data_out   in   [31:0] read data, valid on the last read cycle
//   mem_read          out  memory read strobe
//   load_busy         out  high whenever not idle
//   load_done         out  one-cycle completion pulse
//   load_error        out  one-cycle pulse with load_done on a rejected request
//   load_size_out     out  [31:0] extended load result, held between loads

module load_size_ctrl #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic [1:0]  load_size_control,
  input  logic [1:0]  addr_low,
  input  logic        load_signed,
  input  logic [31:0] memory_data_out,
  output logic        mem_read,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_error,
  output logic [31:0] load_size_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter value of the final READ cycle
  localparam logic [3:0] LP_LAST = 4'(MEM_LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_size;
  logic [1:0]  r_addr;
  logic        r_signed;
  logic        r_mem_read;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [31:0] r_out;

  logic        w_illegal;
  logic        w_sext_en;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Misaligned halfword/word or the reserved size code
  assign w_illegal = (load_size_control == 2'b11) ||
                     ((load_size_control == 2'b01) && addr_low[0]) ||
                     ((load_size_control == 2'b10) && (addr_low != 2'b00));

`ifdef LOAD_SIGN_EXT_EN
  assign w_sext_en = r_signed;
`else
  // Signedness is still latched so the port stays functional-looking, but it
  // has no effect on the result in this build.
  logic w_unused_signed;
  assign w_unused_signed = r_signed;
  assign w_sext_en       = 1'b0;
`endif

  always_comb begin
    w_byte = memory_data_out[7:0];
    case (r_addr)
      2'd0:    w_byte = memory_data_out[7:0];
      2'd1:    w_byte = memory_data_out[15:8];
      2'd2:    w_byte = memory_data_out[23:16];
      default: w_byte = memory_data_out[31:24];
    endcase
    w_half = r_addr[1] ? memory_data_out[31:16] : memory_data_out[15:0];
    case (r_size)
      2'b00:   w_ext = {{24{w_sext_en & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{w_sext_en & w_half[15]}}, w_half};
      default: w_ext = memory_data_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_size     <= 2'b00;
      r_addr     <= 2'b00;
      r_signed   <= 1'b0;
      r_mem_read <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_out      <= 32'd0;
    end else begin
      // done/error are single-cycle pulses
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_req) begin
            r_size   <= load_size_control;
            r_addr   <= addr_low;
            r_signed <= load_signed;
            r_busy   <= 1'b1;
            if (w_illegal) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state    <= ST_READ;
              r_mem_read <= 1'b1;
              r_cnt      <= 4'd0;
            end
          end
        end
        ST_READ: begin
          if (r_cnt == LP_LAST) begin
            r_state    <= ST_DONE;
            r_mem_read <= 1'b0;
            r_done     <= 1'b1;
            r_out      <= w_ext;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_mem_read <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read      = r_mem_read;
  assign load_busy     = r_busy;
  assign load_done     = r_done;
  assign load_error    = r_error;
  assign load_size_out = r_out;

endmodule

// File: doc/load_size_ctrl.md
LOAD_SIZE_CTRL -- requirements
Module: load_size_ctrl

Interface
REQ-001 Parameter: MEM_LATENCY, default 2, number of cycles mem_read is held high per access (legal 1..15).
REQ-002 Ports: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 load_req  input  1  load request, sampled only in IDLE.
REQ-006 load_size_control  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 addr_low  input  2  byte offset of the load address.
REQ-008 load_signed  input  1  1 = sign-extend, 0 = zero-extend (see REQ-027).
REQ-009 memory_data_out  input  32  memory read data, valid on the last READ cycle.
REQ-010 mem_read  output  1  memory read strobe.
REQ-011 load_busy  output  1  high whenever state is not IDLE.
REQ-012 load_done  output  1  one-cycle completion pulse.
REQ-013 load_error  output  1  one-cycle pulse, coincident with load_done, on a rejected request.
REQ-014 load_size_out  output  32  extended load result, registered.

Function
REQ-015 States SHALL be IDLE, READ, DONE.
- IDLE->READ: on load_req=1 with a legal request.
- IDLE->DONE: on load_req=1 with an illegal request.
- READ->DONE: after MEM_LATENCY cycles.
- DONE->IDLE: unconditionally.
REQ-016 On acceptance (edge T), the block SHALL latch load_size_control, addr_low and load_signed; later input changes SHALL have no effect on that access.
REQ-017 mem_read SHALL be 1 exactly in cycles T+1..T+MEM_LATENCY (READ state), counted by an internal 4-bit counter.
REQ-018 At the edge ending the last READ cycle, memory_data_out SHALL be captured, extracted and extended into load_size_out.
REQ-019 load_done SHALL be 1 for exactly cycle T+MEM_LATENCY+1 (DONE); latency from acceptance to done is MEM_LATENCY+1 cycles.
REQ-020 Byte extraction: bits [8*addr_low+7 : 8*addr_low] of memory_data_out, extended to 32 bits.
REQ-021 Halfword extraction: bits [16*addr_low[1]+15 : 16*addr_low[1]], extended to 32 bits.
REQ-022 Word: load_size_out = memory_data_out unchanged.
REQ-023 Illegal request = size 11, or halfword with addr_low[0]=1, or word with addr_low!=00.
- mem_read SHALL never assert.
- load_done and load_error SHALL both be 1 in cycle T+1.
- load_size_out SHALL hold its previous value.
REQ-024 load_req while busy, including during DONE, SHALL be ignored and not queued.
REQ-025 load_size_out SHALL hold its value between completions.

Reset
REQ-026 Reset SHALL force IDLE and clear the counter and latched controls; mem_read, load_busy, load_done, load_error and load_size_out SHALL be 0, immediately and asynchronously, including mid-READ; the aborted access SHALL produce no load_done.

Configuration
REQ-027 Macro LOAD_SIGN_EXT_EN:
- Defined: load_signed selects sign or zero extension for byte and halfword loads.
- Undefined: all loads zero-extend and load_signed is ignored; the port remains present.

Verification
REQ-028 MEM_LATENCY=2, byte load, addr_low=01, load_signed=1, macro defined, memory_data_out=0x1234_80FF -> mem_read high 2 cycles; load_done in cycle T+3; load_size_out=0xFFFF_FF80.
REQ-029 Same stimulus with the macro undefined -> load_size_out=0x0000_0080.
REQ-030 Halfword load, addr_low=10, load_signed=0, memory_data_out=0xABCD_0001 -> load_size_out=0x0000_ABCD; word load, addr_low=00 -> 0xABCD_0001.
REQ-031 Word load with addr_low=10 -> mem_read stays 0; load_done=load_error=1 in cycle T+1; load_size_out unchanged.
REQ-032 load_req held high continuously for 10 cycles with MEM_LATENCY=2 -> exactly 3 accesses accepted, at T, T+4 and T+8, none during READ or DONE.
REQ-033 Reset pulsed during the second READ cycle -> mem_read and load_busy drop in the same cycle; no load_done; the next request completes normally.
